fm_discriminator: RTL
=====================

FM_DISCRIMINATOR -- requirements
Module: fm_discriminator

Interface
REQ-001 Parameter WIDTH, default 16: sample width of I, Q and the output, in bits.
REQ-002 Parameter ITER, default 14: number of CORDIC iterations, legal range 8..WIDTH.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  one-cycle strobe; i_i/q_i hold a new complex baseband sample.
REQ-006 i_i  input  WIDTH  signed in-phase sample.
REQ-007 q_i  input  WIDTH  signed quadrature sample.
REQ-008 data_o  output  WIDTH  signed instantaneous frequency, which is the phase difference to the previous sample; feeds the DC-removal averager data_i.
REQ-009 start_o  output  1  one-cycle strobe marking a new data_o; drives the averager start_i.
REQ-010 busy_o  output  1  high while a sample is being processed.

Function
REQ-011 The block SHALL compute phase = atan2(q_i, i_i) with a sequential vectoring CORDIC, scaled so that +pi maps to 2^(WIDTH-1) and -pi maps to -2^(WIDTH-1), in WIDTH-bit two's complement.
REQ-012 The FSM SHALL have states IDLE, PRE, ITER, DIFF and OUT; any state other than these SHALL return to IDLE.
REQ-013 IDLE: on valid_i the block SHALL register i_i/q_i, go to PRE and raise busy_o.
REQ-014 PRE: for i<0 the block SHALL rotate the vector by pi (negate I and Q) and preset the angle accumulator to +-pi according to the sign of Q (Q>=0 gives +pi); otherwise it SHALL preset the accumulator to 0.
REQ-015 ITER: the block SHALL perform one micro-rotation per cycle, k = 0..ITER-1, using an internal constant atan(2^-k) table in the phase scaling, with a datapath of WIDTH+2 bits to prevent overflow from CORDIC gain.
REQ-016 DIFF: the block SHALL set data_o = phase - prev_phase, truncated to WIDTH bits so that wrap-around across +-pi yields the short-way difference, and SHALL update prev_phase to phase.
REQ-017 OUT: the block SHALL pulse start_o for exactly one cycle, drop busy_o and return to IDLE.
REQ-018 Latency from a valid_i cycle to the start_o cycle SHALL be exactly ITER+3 clocks.
REQ-019 data_o SHALL hold its value until the next DIFF.
REQ-020 For i_i = q_i = 0 the block SHALL use phase 0.
REQ-021 For i_i = -2^(WIDTH-1) the negation SHALL be performed in the WIDTH+2 datapath with no saturation.
REQ-022 valid_i while busy_o is high SHALL be ignored and the sample dropped.
REQ-023 valid_i in the same cycle as OUT SHALL be ignored; it is accepted only in IDLE.
REQ-024 Phase accuracy SHALL be within +-2 LSB for |I|,|Q| >= 2^(WIDTH-4), and data_o accuracy within +-4 LSB.

Reset
REQ-025 On rst the block SHALL go immediately to IDLE with data_o=0, start_o=0, busy_o=0, prev_phase=0 and all datapath registers at 0.
REQ-026 rst asserted mid-computation SHALL abort that sample with no start_o.
REQ-027 The first sample after reset SHALL be differenced against prev_phase=0.

Configuration
REQ-028 With macro FM_DISC_OVERRUN_EN defined, the block SHALL add output overrun_o (1 bit), which is set by any dropped valid_i (REQ-022/023), is sticky, and is cleared only by rst.
REQ-029 Without FM_DISC_OVERRUN_EN, the overrun_o port and its logic SHALL be absent and dropped samples SHALL go unflagged; all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then I=16384, Q=0 -> start_o exactly 17 clocks after valid_i (ITER=14), data_o = 0 +-4.
REQ-031 Next sample I=0, Q=16384 -> data_o = 16384 +-4; next sample I=-16384, Q=0 -> data_o = 16384 +-4 (phase = -32768, REQ-014).
REQ-032 Wrap: phase +0.9pi (I=-15582, Q=5063) then -0.9pi (I=-15582, Q=-5063) -> data_o = +6554 +-4, not negative.
REQ-033 Constant rotation of +pi/8 per sample over 64 samples with amplitude 12000 -> every data_o after the first = 4096 +-4, with exactly 64 start_o pulses.
REQ-034 valid_i pulsed 5 clocks after an accepted sample -> sample dropped, a single start_o, and overrun_o=1 when FM_DISC_OVERRUN_EN is defined; rst asserted during ITER -> no start_o, outputs 0, next sample differenced against 0.

Source files
------------

// File: rtl/fm_discriminator.sv
// FM discriminator: sequential vectoring CORDIC extracts atan2(Q, I), then differences it against the previous phase.
// Optional macro FM_DISC_OVERRUN_EN adds a sticky overrun_o flag for samples dropped while the block was busy.
module fm_discriminator #(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] i_i,
    input  logic signed [WIDTH-1:0] q_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    start_o,
    output logic                    busy_o
`ifdef FM_DISC_OVERRUN_EN
    ,
    output logic                    overrun_o
`endif
);

    localparam int AW   = WIDTH + 2;
    localparam int KW   = $clog2(ITER);
    localparam int SH   = (WIDTH < 32) ? 32 - WIDTH : 0;
    localparam int SHM1 = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [AW-1:0] PHASE_PI = {3'b001, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_DIFF = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // atan(2^-k) with a full turn mapped to 2^32; rescaled to the WIDTH-bit phase below.
    function automatic logic [31:0] atan_raw(input int k);
        case (k)
            0:  return 32'd536870912;
            1:  return 32'd316933406;
            2:  return 32'd167458907;
            3:  return 32'd85004756;
            4:  return 32'd42667331;
            5:  return 32'd21354465;
            6:  return 32'd10679838;
            7:  return 32'd5340245;
            8:  return 32'd2670163;
            9:  return 32'd1335087;
            10: return 32'd667544;
            11: return 32'd333772;
            12: return 32'd166886;
            13: return 32'd83443;
            14: return 32'd41722;
            15: return 32'd20861;
            16: return 32'd10430;
            17: return 32'd5215;
            18: return 32'd2608;
            19: return 32'd1304;
            20: return 32'd652;
            21: return 32'd326;
            22: return 32'd163;
            23: return 32'd81;
            24: return 32'd41;
            25: return 32'd20;
            26: return 32'd10;
            27: return 32'd5;
            28: return 32'd3;
            29: return 32'd1;
            30: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic signed [AW-1:0] atan_lut(input int k);
        logic [32:0] t;
        t = {1'b0, atan_raw(k)};
        if (SH > 0) t = (t + (33'd1 << SHM1)) >> SH;
        return AW'(t);
    endfunction

    state_t state_q, state_d;
    logic signed [AW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [AW-1:0]    xs, ys;
    logic [KW-1:0]           k_q, k_d;
    logic                    zero_q, zero_d;
    logic signed [WIDTH-1:0] data_q, data_d, prev_q, prev_d, phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = valid_i ? S_PRE : S_IDLE;
            S_PRE:   state_d = S_ITER;
            S_ITER:  state_d = (k_q == KW'(ITER - 1)) ? S_DIFF : S_ITER;
            S_DIFF:  state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == S_PRE) || (state_q == S_ITER) || (state_q == S_DIFF);
        start_o = (state_q == S_OUT);
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        k_d    = k_q;
        zero_d = zero_q;
        data_d = data_q;
        prev_d = prev_q;
        xs     = x_q >>> k_q;
        ys     = y_q >>> k_q;
        phase  = zero_q ? '0 : z_q[WIDTH-1:0];
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    x_d = AW'(i_i);
                    y_d = AW'(q_i);
                end
            end
            S_PRE: begin
                // Left half-plane: rotate by pi so the iterations only see x >= 0.
                zero_d = (x_q == '0) && (y_q == '0);
                k_d    = '0;
                if (x_q[AW-1]) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = y_q[AW-1] ? -PHASE_PI : PHASE_PI;
                end else begin
                    z_d = '0;
                end
            end
            S_ITER: begin
                if (!y_q[AW-1]) begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + atan_lut(int'(k_q));
                end else begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - atan_lut(int'(k_q));
                end
                k_d = k_q + KW'(1);
            end
            S_DIFF: begin
                // Truncation to WIDTH bits makes the difference wrap the short way round.
                data_d = phase - prev_q;
                prev_d = phase;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            k_q    <= '0;
            zero_q <= 1'b0;
            data_q <= '0;
            prev_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            k_q    <= k_d;
            zero_q <= zero_d;
            data_q <= data_d;
            prev_q <= prev_d;
        end
    end

    assign data_o = data_q;

`ifdef FM_DISC_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb overrun_d = overrun_q | (valid_i && (state_q != S_IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    assign overrun_o = overrun_q;
`endif

endmodule
